// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file.
// Provides two combinational read ports with WB->ID bypass and counts retired instructions.
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_0400,
    parameter int          COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic [31:0]        wb_instruction,
    input  logic [31:0]        wb_rdata,
    input  logic [31:0]        wb_alu_result,
    input  logic [31:0]        wb_pc_plus4,
    input  logic [1:0]         wb_reg_dst,
    input  logic               wb_reg_wr,
    input  logic [1:0]         wb_mem_to_reg,
    input  logic [4:0]         rs_addr,
    input  logic [4:0]         rt_addr,
    output logic [31:0]        rs_data,
    output logic [31:0]        rt_data,
    output logic               fwd_wr_en,
    output logic [4:0]         fwd_wr_addr,
    output logic [31:0]        fwd_wr_data,
    output logic [COUNT_W-1:0] retired_count
);

    logic [31:0]        regs [32];
    logic [COUNT_W-1:0] count_reg;
    logic [4:0]         wr_addr;
    logic [31:0]        wr_data;
    logic               wr_en;

    // Only the rt/rd fields of the instruction select a destination.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{wb_instruction[31:21], wb_instruction[10:0]};

    always_comb begin
        wr_addr = 5'd26;
        case (wb_reg_dst)
            2'd0:    wr_addr = wb_instruction[20:16];
            2'd1:    wr_addr = wb_instruction[15:11];
            2'd2:    wr_addr = 5'd31;
            default: wr_addr = 5'd26;
        endcase
    end

    always_comb begin
        wr_data = wb_alu_result;
        case (wb_mem_to_reg)
            2'd1:    wr_data = wb_rdata;
            2'd2:    wr_data = wb_pc_plus4;
            default: wr_data = wb_alu_result;
        endcase
    end

    assign wr_en       = wb_valid & wb_reg_wr & (wr_addr != 5'd0);
    assign fwd_wr_en   = wr_en;
    assign fwd_wr_addr = wr_addr;
    assign fwd_wr_data = wr_data;

    // Both read ports share the same rules: $0 is hardwired, then bypass, then array.
    logic [4:0]  rd_addr [2];
    logic [31:0] rd_data [2];
    assign rd_addr[0] = rs_addr;
    assign rd_addr[1] = rt_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rd_data[gi] = regs[rd_addr[gi]];
                if (rd_addr[gi] == 5'd0) begin
                    rd_data[gi] = 32'd0;
                end else if (wr_en && (rd_addr[gi] == wr_addr)) begin
                    rd_data[gi] = wr_data;
                end
            end
        end
    endgenerate

    assign rs_data = rd_data[0];
    assign rt_data = rd_data[1];

    // Reset wins over a coincident write, so a write in the reset cycle is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= (i == 29) ? SP_INIT : 32'd0;
            end
            count_reg <= '0;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (wb_valid) begin
                count_reg <= count_reg + COUNT_W'(1);
            end
        end
    end

    assign retired_count = count_reg;

endmodule
